// File: rtl/pong_sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : pong_sprite_renderer
//  Purpose  : Draws N_SPRITES rectangular sprites over a flat background.
//             The CPU loads a shadow sprite table. A commit copies the whole
//             shadow table into the active table at the next frame_start,
//             so a frame is always drawn from one consistent table.
//             Stage 1 registers the per-sprite hit vector, pix_valid and
//             sync_in. Stage 2 selects the colour and registers rgb_out.
//  Ports    : clk, rst (async, active-low)
//             h_cnt, v_cnt, pix_valid, sync_in, frame_start  - timing in
//             wr_en, wr_idx, wr_px/py/hw/hh, wr_color,
//             wr_enable, cfg_commit                          - CPU side
//             commit_pending                                 - status
//             rgb_out, rgb_valid, sync_out                   - VGA out
//  Revision : 1.0  initial release
// ============================================================================
module pong_sprite_renderer #(
    parameter int          N_SPRITES = 4,
    parameter int          IDX_W     = 2,
    parameter int          COORD_W   = 16,
    parameter logic [11:0] BG_COLOR  = 12'h111,
    parameter int          LATENCY   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] h_cnt,
    input  logic [COORD_W-1:0] v_cnt,
    input  logic               pix_valid,
    input  logic [1:0]         sync_in,
    input  logic               frame_start,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_px,
    input  logic [COORD_W-1:0] wr_py,
    input  logic [COORD_W-1:0] wr_hw,
    input  logic [COORD_W-1:0] wr_hh,
    input  logic [11:0]        wr_color,
    input  logic               wr_enable,
    input  logic               cfg_commit,
    output logic               commit_pending,
    output logic [11:0]        rgb_out,
    output logic               rgb_valid,
    output logic [1:0]         sync_out
);

    localparam logic [IDX_W:0] c_N_SPR = (IDX_W+1)'(N_SPRITES);

    // Shadow (CPU-written) and active (frame-stable) sprite tables
    logic [COORD_W-1:0] r_sh_px    [N_SPRITES];
    logic [COORD_W-1:0] r_sh_py    [N_SPRITES];
    logic [COORD_W-1:0] r_sh_hw    [N_SPRITES];
    logic [COORD_W-1:0] r_sh_hh    [N_SPRITES];
    logic [11:0]        r_sh_color [N_SPRITES];
    logic               r_sh_en    [N_SPRITES];

    logic [COORD_W-1:0] r_act_px    [N_SPRITES];
    logic [COORD_W-1:0] r_act_py    [N_SPRITES];
    logic [COORD_W-1:0] r_act_hw    [N_SPRITES];
    logic [COORD_W-1:0] r_act_hh    [N_SPRITES];
    logic [11:0]        r_act_color [N_SPRITES];
    logic               r_act_en    [N_SPRITES];

    logic                 r_commit_pending;
    logic                 w_commit_now;
    logic                 w_wr_ok;
    logic [N_SPRITES-1:0] w_hit;
    logic [N_SPRITES-1:0] r_hit;
    logic                 r_vld_pipe  [LATENCY];
    logic [1:0]           r_sync_pipe [LATENCY];
    logic [11:0]          w_color;
    logic [11:0]          r_rgb;

    assign w_commit_now = frame_start && (r_commit_pending || cfg_commit);
    assign w_wr_ok      = wr_en && ({1'b0, wr_idx} < c_N_SPR);

    // ------------------------------------------------------------------
    // Sprite tables and commit handshake. The active copy uses the
    // pre-edge shadow contents, so a write landing on the commit edge
    // only reaches the shadow table.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                r_sh_px[i]     <= '0;
                r_sh_py[i]     <= '0;
                r_sh_hw[i]     <= '0;
                r_sh_hh[i]     <= '0;
                r_sh_color[i]  <= '0;
                r_sh_en[i]     <= 1'b0;
                r_act_px[i]    <= '0;
                r_act_py[i]    <= '0;
                r_act_hw[i]    <= '0;
                r_act_hh[i]    <= '0;
                r_act_color[i] <= '0;
                r_act_en[i]    <= 1'b0;
            end
            r_commit_pending <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_sh_px[wr_idx]    <= wr_px;
                r_sh_py[wr_idx]    <= wr_py;
                r_sh_hw[wr_idx]    <= wr_hw;
                r_sh_hh[wr_idx]    <= wr_hh;
                r_sh_color[wr_idx] <= wr_color;
                r_sh_en[wr_idx]    <= wr_enable;
            end
            if (w_commit_now) begin
                for (int i = 0; i < N_SPRITES; i++) begin
                    r_act_px[i]    <= r_sh_px[i];
                    r_act_py[i]    <= r_sh_py[i];
                    r_act_hw[i]    <= r_sh_hw[i];
                    r_act_hh[i]    <= r_sh_hh[i];
                    r_act_color[i] <= r_sh_color[i];
                    r_act_en[i]    <= r_sh_en[i];
                end
                r_commit_pending <= 1'b0;
            end else if (cfg_commit) begin
                r_commit_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-sprite hit test. On the commit cycle the first pixel of the new
    // frame is tested against the shadow values being committed, so the
    // new table is visible from that pixel on. Sums are one bit wider
    // than the coordinates so neither edge of the screen wraps.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_sprite
            logic [COORD_W:0] w_px;
            logic [COORD_W:0] w_py;
            logic [COORD_W:0] w_hw;
            logic [COORD_W:0] w_hh;
            logic             w_en;
            logic [COORD_W:0] w_h;
            logic [COORD_W:0] w_v;

            assign w_px = {1'b0, w_commit_now ? r_sh_px[gi] : r_act_px[gi]};
            assign w_py = {1'b0, w_commit_now ? r_sh_py[gi] : r_act_py[gi]};
            assign w_hw = {1'b0, w_commit_now ? r_sh_hw[gi] : r_act_hw[gi]};
            assign w_hh = {1'b0, w_commit_now ? r_sh_hh[gi] : r_act_hh[gi]};
            assign w_en = w_commit_now ? r_sh_en[gi] : r_act_en[gi];
            assign w_h  = {1'b0, h_cnt};
            assign w_v  = {1'b0, v_cnt};

            assign w_hit[gi] = w_en
                            && ((w_h + w_hw) > w_px) && (w_h < (w_px + w_hw))
                            && ((w_v + w_hh) > w_py) && (w_v < (w_py + w_hh));
        end
    endgenerate

    // Stage 1 captures the hit vector; valid/sync travel in a delay line
    // whose first tap is the stage-1 value and last tap drives the pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_vld_pipe[i]  <= 1'b0;
                r_sync_pipe[i] <= 2'b00;
            end
        end else begin
            r_hit          <= w_hit;
            r_vld_pipe[0]  <= pix_valid;
            r_sync_pipe[0] <= sync_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_sync_pipe[i] <= r_sync_pipe[i-1];
            end
        end
    end

    // Lowest index wins: scan from the top so lower indices overwrite.
    always_comb begin
        w_color = BG_COLOR;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (r_hit[i]) begin
                w_color = r_act_color[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb <= 12'h000;
        end else begin
            r_rgb <= r_vld_pipe[0] ? w_color : 12'h000;
        end
    end

    assign commit_pending = r_commit_pending;
    assign rgb_out        = r_rgb;
    assign rgb_valid      = r_vld_pipe[LATENCY-1];
    assign sync_out       = r_sync_pipe[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_pong_sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_sprite_renderer
//  Purpose  : Directed self-checking bench for pong_sprite_renderer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pong_sprite_renderer;

    logic        clk;
    logic        rst;
    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
    logic        pix_valid;
    logic [1:0]  sync_in;
    logic        frame_start;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [15:0] wr_px;
    logic [15:0] wr_py;
    logic [15:0] wr_hw;
    logic [15:0] wr_hh;
    logic [11:0] wr_color;
    logic        wr_enable;
    logic        cfg_commit;
    logic        commit_pending;
    logic [11:0] rgb_out;
    logic        rgb_valid;
    logic [1:0]  sync_out;

    int n_total = 0;
    int n_bad   = 0;

    logic       v_hist [0:63];
    logic [1:0] s_hist [0:63];

    pong_sprite_renderer #(
        .N_SPRITES (4),
        .IDX_W     (2),
        .COORD_W   (16),
        .BG_COLOR  (12'h111),
        .LATENCY   (2)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .h_cnt          (h_cnt),
        .v_cnt          (v_cnt),
        .pix_valid      (pix_valid),
        .sync_in        (sync_in),
        .frame_start    (frame_start),
        .wr_en          (wr_en),
        .wr_idx         (wr_idx),
        .wr_px          (wr_px),
        .wr_py          (wr_py),
        .wr_hw          (wr_hw),
        .wr_hh          (wr_hh),
        .wr_color       (wr_color),
        .wr_enable      (wr_enable),
        .cfg_commit     (cfg_commit),
        .commit_pending (commit_pending),
        .rgb_out        (rgb_out),
        .rgb_valid      (rgb_valid),
        .sync_out       (sync_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] idx, input logic [15:0] px, input logic [15:0] py,
                      input logic [15:0] hw, input logic [15:0] hh,
                      input logic [11:0] col, input logic en);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = idx; wr_px = px; wr_py = py;
        wr_hw = hw; wr_hh = hh; wr_color = col; wr_enable = en;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Present one valid pixel (optionally as the frame_start pixel) and
    // check the colour two clock edges later.
    task automatic probe(input string tag, input logic [15:0] h, input logic [15:0] v,
                         input logic fs, input logic [11:0] exp);
        @(negedge clk);
        h_cnt = h; v_cnt = v; pix_valid = 1'b1; sync_in = 2'b11; frame_start = fs;
        @(negedge clk);
        frame_start = 1'b0;
        @(posedge clk);
        #1;
        check(tag, {20'd0, rgb_out}, {20'd0, exp});
    endtask

    initial begin
        rst = 1'b0;
        h_cnt = '0; v_cnt = '0; pix_valid = 1'b0; sync_in = 2'b00; frame_start = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_px = '0; wr_py = '0; wr_hw = '0; wr_hh = '0;
        wr_color = '0; wr_enable = 1'b0; cfg_commit = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb",     {20'd0, rgb_out},   32'd0);
        check("rst_valid",   {31'd0, rgb_valid}, 32'd0);
        check("rst_sync",    {30'd0, sync_out},  32'd0);
        check("rst_pending", {31'd0, commit_pending}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- background stream, 2-cycle delay ----------------
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            pix_valid = 1'($urandom);
            sync_in   = 2'($urandom);
            h_cnt     = 16'($urandom_range(0, 799));
            v_cnt     = 16'($urandom_range(0, 524));
            v_hist[k] = pix_valid;
            s_hist[k] = sync_in;
            @(posedge clk);
            #1;
            if (k >= 1) begin
                check("bg_valid", {31'd0, rgb_valid}, {31'd0, v_hist[k-1]});
                check("bg_sync",  {30'd0, sync_out},  {30'd0, s_hist[k-1]});
                check("bg_rgb",   {20'd0, rgb_out},   v_hist[k-1] ? 32'h111 : 32'h0);
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        sync_in   = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("blank_rgb", {20'd0, rgb_out}, 32'd0);

        // ---------------- single sprite ----------------
        wr(2'd0, 16'd100, 16'd50, 16'd10, 16'd5, 12'hF00, 1'b1);
        probe("no_commit_yet", 16'd100, 16'd50, 1'b0, 12'h111);
        commit();
        check("pending_set", {31'd0, commit_pending}, 32'd1);
        commit();
        check("pending_repeat", {31'd0, commit_pending}, 32'd1);
        frame();
        check("pending_clr", {31'd0, commit_pending}, 32'd0);
        probe("s0_left",   16'd91,  16'd46, 1'b0, 12'hF00);
        probe("s0_right",  16'd109, 16'd54, 1'b0, 12'hF00);
        probe("s0_centre", 16'd100, 16'd50, 1'b0, 12'hF00);
        probe("s0_x90",    16'd90,  16'd50, 1'b0, 12'h111);
        probe("s0_x110",   16'd110, 16'd50, 1'b0, 12'h111);
        probe("s0_y45",    16'd100, 16'd45, 1'b0, 12'h111);
        probe("s0_y55",    16'd100, 16'd55, 1'b0, 12'h111);

        // ---------------- overlap / priority ----------------
        wr(2'd2, 16'd100, 16'd50, 16'd10, 16'd5, 12'h0F0, 1'b1);
        commit();
        frame();
        probe("prio_idx0", 16'd100, 16'd50, 1'b0, 12'hF00);
        wr(2'd0, 16'd100, 16'd50, 16'd10, 16'd5, 12'hF00, 1'b0);
        probe("midframe_wr", 16'd100, 16'd50, 1'b0, 12'hF00);
        commit();
        probe("pending_old", 16'd100, 16'd50, 1'b0, 12'hF00);
        probe("first_pix_new", 16'd100, 16'd50, 1'b1, 12'h0F0);
        check("pending_fs_clr", {31'd0, commit_pending}, 32'd0);
        probe("after_new", 16'd95, 16'd52, 1'b0, 12'h0F0);

        // ---------------- screen edges ----------------
        wr(2'd1, 16'd3, 16'd50, 16'd10, 16'd5, 12'h00F, 1'b1);
        @(negedge clk);
        cfg_commit = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0; frame_start = 1'b0;
        check("commit_fs_same", {31'd0, commit_pending}, 32'd0);
        probe("edge_h0", 16'd0, 16'd50, 1'b0, 12'h00F);
        wr(2'd3, 16'hFFFF, 16'd50, 16'd2, 16'd5, 12'hFFF, 1'b1);
        commit();
        frame();
        probe("edge_hi_hit",  16'hFFFE, 16'd50, 1'b0, 12'hFFF);
        probe("edge_hi_miss", 16'hFFFD, 16'd50, 1'b0, 12'h111);

        // ---------------- commit + frame_start + write together ----------------
        @(negedge clk);
        cfg_commit = 1'b1; frame_start = 1'b1;
        wr_en = 1'b1; wr_idx = 2'd3; wr_px = 16'hFFFF; wr_py = 16'd50;
        wr_hw = 16'd2; wr_hh = 16'd5; wr_color = 12'h0AA; wr_enable = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0; frame_start = 1'b0; wr_en = 1'b0;
        probe("same_cyc_excl", 16'hFFFE, 16'd50, 1'b0, 12'hFFF);
        commit();
        frame();
        probe("same_cyc_next", 16'hFFFE, 16'd50, 1'b0, 12'h0AA);

        // ---------------- reset mid-frame with pending commit ----------------
        wr(2'd1, 16'd3, 16'd50, 16'd10, 16'd5, 12'hABC, 1'b1);
        commit();
        check("pre_rst_pending", {31'd0, commit_pending}, 32'd1);
        @(negedge clk);
        h_cnt = 16'd0; v_cnt = 16'd50; pix_valid = 1'b1; sync_in = 2'b11;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_valid", {31'd0, rgb_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_rgb",     {20'd0, rgb_out},   32'd0);
        check("mid_rst_valid",   {31'd0, rgb_valid}, 32'd0);
        check("mid_rst_sync",    {30'd0, sync_out},  32'd0);
        check("mid_rst_pending", {31'd0, commit_pending}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        frame();
        probe("post_rst_bg0",   16'd0,     16'd50, 1'b0, 12'h111);
        probe("post_rst_bg100", 16'd100,   16'd50, 1'b0, 12'h111);
        probe("post_rst_bghi",  16'hFFFE,  16'd50, 1'b0, 12'h111);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
